relprime_checker: RTL

//  Response-side checker for the relprime datapath. Takes the operand N (register_value) and the result M
//  (out) that the relprime core returns, and computes gcd(N,M) with a sequential binary (Stein) GCD.

---
 rtl/relprime_pkg.sv | 17 +
 rtl/relprime_absdiff.sv | 18 +
 rtl/relprime_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/relprime_pkg.sv
// relprime_pkg: shared types for the relprime response checker.
// Holds the default operand width, the word type and the FSM state enum.
package relprime_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ZCHK,
        STRIP,
        REDUCE,
        FINISH
    } chk_state_t;

endpackage

// File: rtl/relprime_absdiff.sv
// relprime_absdiff: combinational min(a,b) and |a-b| for the GCD reduce step.
// The subtraction is selected by a compare, so it never wraps.
module relprime_absdiff #(
    parameter int W = relprime_pkg::WIDTH
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_diff
);

    logic w_a_lt_b;

    assign w_a_lt_b = (i_a < i_b);
    assign o_min    = w_a_lt_b ? i_a : i_b;
    assign o_diff   = w_a_lt_b ? (i_b - i_a) : (i_a - i_b);

endmodule

// File: rtl/relprime_checker.sv
// relprime_checker: sequential binary (Stein) GCD of N and M with a coprime flag.
// Optional accept-to-done cycle counter enabled by RELPRIME_CYCLE_COUNT_EN.
module relprime_checker #(
    parameter int WIDTH = relprime_pkg::WIDTH
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] value_n,
    input  logic [WIDTH-1:0] value_m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             coprime
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    import relprime_pkg::*;

    localparam int KW = $clog2(WIDTH) + 1;

    chk_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [KW-1:0]    r_k;

    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;

    relprime_absdiff #(
        .W(WIDTH)
    ) u_absdiff (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_min (w_min),
        .o_diff(w_diff)
    );

    // r << k cannot exceed max(N,M), so the shift never truncates
    assign w_res = r_r << r_k;

    // GCD state machine: one strip/reduce action per cycle, registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_k     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gcd     <= '0;
            coprime <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= value_n;
                        r_b     <= value_m;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= ZCHK;
                    end
                end
                ZCHK: begin
                    if (r_a == '0 || r_b == '0) begin
                        r_r     <= r_a | r_b;
                        r_k     <= '0;
                        r_state <= FINISH;
                    end else begin
                        r_state <= STRIP;
                    end
                end
                STRIP: begin
                    if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + KW'(1);
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else begin
                        r_state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (r_b == '0) begin
                        r_r     <= r_a;
                        r_state <= FINISH;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else begin
                        r_a <= w_min;
                        r_b <= w_diff;
                    end
                end
                FINISH: begin
                    gcd     <= w_res;
                    coprime <= (w_res == WIDTH'(1));
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    assign cycles = r_cnt;

    // Busy-cycle counter: cleared on accept, saturates at all ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= '0;
        end else if (busy && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
